pc_unit: RTL and testbench

Parametrised program-counter unit for the four-stage pipeline; successor to the basic free-running PC register. Holds the fetch address and selects the next one each cycle. Supports:
- stall
- branch redirect
- exception vectoring
- call/return through an internal circular return-address stack (RAS)

Feeds the instruction-memory address and the IF/ID pipeline register.

---
 rtl/pc_unit_if.sv | 29 ++
 rtl/pc_unit.sv | 99 +++++++++
 tb/tb_pc_unit.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/pc_unit_if.sv
// Fetch-control bundle between the pipeline control logic and the pc_unit.
// The master drives redirect requests; the slave returns the pc and RAS status.
interface pc_unit_if #(
    parameter int AW = 16
);
    logic          stall;
    logic          exc_valid;
    logic [AW-1:0] exc_vector;
    logic          br_taken;
    logic [AW-1:0] br_target;
    logic          call;
    logic          ret;
    logic [AW-1:0] pc;
    logic          pc_valid;
    logic          ras_empty;
    logic          ras_full;
    logic          ras_overflow;
    logic          ras_underflow;

    modport master (
        output stall, exc_valid, exc_vector, br_taken, br_target, call, ret,
        input  pc, pc_valid, ras_empty, ras_full, ras_overflow, ras_underflow
    );

    modport slave (
        input  stall, exc_valid, exc_vector, br_taken, br_target, call, ret,
        output pc, pc_valid, ras_empty, ras_full, ras_overflow, ras_underflow
    );
endinterface

// File: rtl/pc_unit.sv
// Program counter with stall, branch, exception and call/return redirects.
// Returns come from a circular stack that overwrites its oldest entry when full.
module pc_unit #(
    parameter int          AW        = 16,
    parameter int          STEP      = 1,
    parameter logic [AW-1:0] RESET_VEC = '0,
    parameter int          RAS_DEPTH = 4
) (
    input logic       clk,
    input logic       rst,
    pc_unit_if.slave  bus
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    typedef enum logic [2:0] {
        SEL_EXC, SEL_CALL, SEL_BR, SEL_POP, SEL_UNF, SEL_HOLD, SEL_SEQ
    } sel_e;

    logic [AW-1:0] pc_q;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] top;
    logic [AW-1:0] mem [RAS_DEPTH];
    logic [PW-1:0] wp;
    logic [CW-1:0] cnt;
    logic          valid_q;
    logic          ovf_q;
    logic          unf_q;
    logic          empty;
    logic          full;
    logic          push;
    sel_e          sel;

    assign pc_inc = pc_q + AW'(STEP);
    assign top    = mem[wp - PW'(1)];
    assign empty  = (cnt == '0);
    assign full   = (cnt == CW'(RAS_DEPTH));

    always_comb begin
        sel = SEL_SEQ;
        if (bus.exc_valid)     sel = SEL_EXC;
        else if (bus.call)     sel = SEL_CALL;
        else if (bus.br_taken) sel = SEL_BR;
        else if (bus.ret)      sel = empty ? SEL_UNF : SEL_POP;
        else if (bus.stall)    sel = SEL_HOLD;
    end

    // The first edge out of reset only raises pc_valid.
    assign push = !rst && valid_q && (sel == SEL_CALL);

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= pc_inc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_VEC;
            valid_q <= 1'b0;
            cnt     <= '0;
            wp      <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (!valid_q) begin
            valid_q <= 1'b1;
        end else begin
            unique case (sel)
                SEL_EXC: begin
                    pc_q <= bus.exc_vector;
                    cnt  <= '0;
                end
                SEL_CALL: begin
                    pc_q <= bus.br_target;
                    wp   <= wp + PW'(1);
                    if (full) ovf_q <= 1'b1;
                    else      cnt   <= cnt + CW'(1);
                end
                SEL_BR: pc_q <= bus.br_target;
                SEL_POP: begin
                    pc_q <= top;
                    wp   <= wp - PW'(1);
                    cnt  <= cnt - CW'(1);
                end
                SEL_UNF: begin
                    pc_q  <= pc_inc;
                    unf_q <= 1'b1;
                end
                SEL_HOLD: pc_q <= pc_q;
                default:  pc_q <= pc_inc;
            endcase
        end
    end

    assign bus.pc            = pc_q;
    assign bus.pc_valid      = valid_q;
    assign bus.ras_empty     = empty;
    assign bus.ras_full      = full;
    assign bus.ras_overflow  = ovf_q;
    assign bus.ras_underflow = unf_q;
endmodule

// File: tb/tb_pc_unit.sv
// Randomised and directed bench for pc_unit against a queue-based reference.
// The reference keeps the return stack as a bounded queue of addresses.
module tb_pc_unit;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    pc_unit_if #(.AW(16)) bus ();

    pc_unit #(
        .AW(16), .STEP(1), .RESET_VEC(16'h0000), .RAS_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [15:0] m_pc;
    bit          m_valid;
    bit          m_ovf;
    bit          m_unf;
    logic [15:0] m_ras [$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_edge();
        if (rst) begin
            m_pc = 16'h0000;
            m_valid = 1'b0;
            m_ras.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (!m_valid) begin
            m_valid = 1'b1;
        end else if (bus.exc_valid) begin
            m_pc = bus.exc_vector;
            m_ras.delete();
        end else if (bus.call) begin
            if (m_ras.size() == DEPTH) begin
                void'(m_ras.pop_front());
                m_ovf = 1'b1;
            end
            m_ras.push_back(m_pc + 16'd1);
            m_pc = bus.br_target;
        end else if (bus.br_taken) begin
            m_pc = bus.br_target;
        end else if (bus.ret) begin
            if (m_ras.size() > 0) begin
                m_pc = m_ras.pop_back();
            end else begin
                m_pc = m_pc + 16'd1;
                m_unf = 1'b1;
            end
        end else if (!bus.stall) begin
            m_pc = m_pc + 16'd1;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("pc_valid", 32'(bus.pc_valid), 32'(m_valid));
        chk("pc", 32'(bus.pc), 32'(m_pc));
        chk("ras_empty", 32'(bus.ras_empty), 32'(m_ras.size() == 0));
        chk("ras_full", 32'(bus.ras_full), 32'(m_ras.size() == DEPTH));
        chk("ras_overflow", 32'(bus.ras_overflow), 32'(m_ovf));
        chk("ras_underflow", 32'(bus.ras_underflow), 32'(m_unf));
    endtask

    task automatic drive(input bit st, input bit ex, input logic [15:0] ev,
                         input bit br, input logic [15:0] bt,
                         input bit ca, input bit re);
        bus.stall      = st;
        bus.exc_valid  = ex;
        bus.exc_vector = ev;
        bus.br_taken   = br;
        bus.br_target  = bt;
        bus.call       = ca;
        bus.ret        = re;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic jump(input logic [15:0] t);
        drive(0, 0, 0, 1, t, 0, 0);
    endtask

    initial begin
        bus.stall = 0; bus.exc_valid = 0; bus.exc_vector = 0;
        bus.br_taken = 0; bus.br_target = 0; bus.call = 0; bus.ret = 0;

        // reset, sequential count and wrap
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(4);
        jump(16'hFFFF);
        idle(2);

        // stall, then branch while stalled
        jump(16'h0005);
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 16'h0040, 0, 0);
        idle(1);

        // nested call/return
        jump(16'h0010);
        drive(0, 0, 0, 0, 16'h0100, 1, 0);
        idle(5);
        drive(0, 0, 0, 0, 16'h0200, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 1);

        // overflow then drain past empty
        jump(16'h0001);
        for (int i = 2; i <= 6; i++) drive(0, 0, 0, 0, 16'(i), 1, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 0, 1);

        // priority collisions
        drive(0, 0, 0, 0, 16'h0300, 1, 0);
        drive(1, 1, 16'h0008, 1, 16'h0500, 1, 1);
        drive(0, 0, 0, 1, 16'h0030, 1, 1);
        drive(0, 0, 0, 1, 16'h0050, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 1);

        // reset during a return
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 16'(16'h0700 + i), 1, 0);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 1);
        rst = 1'b0;
        idle(3);

        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            drive(($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 31) == 0), 16'($urandom),
                  ($urandom_range(0, 7) == 0), 16'($urandom),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 4) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
